// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART byte transmitter between NUM_REQ requesters
// Optional WAIT_END watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TX_DATA_WIDTH  = 8,
    parameter int GAP_CYCLES     = 5208,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [NUM_REQ-1:0]                 req_i,
    input  logic [NUM_REQ*TX_DATA_WIDTH-1:0]   data_i,
    output logic [NUM_REQ-1:0]                 grant_o,
    output logic [NUM_REQ-1:0]                 done_o,
    output logic                               uart_tx_start_o,
    output logic [TX_DATA_WIDTH-1:0]           uart_data_tx_o,
    input  logic                               uart_tx_end_i,
    output logic                               busy_o,
    output logic                               timeout_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TX_DATA_WIDTH < 1 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: illegal parameter value");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_END,
        S_GAP
    } state_t;

    state_t                     r_state;
    logic [PTR_W-1:0]           r_ptr;
    logic [NUM_REQ-1:0]         r_grant;
    logic [NUM_REQ-1:0]         r_done;
    logic                       r_start;
    logic [TX_DATA_WIDTH-1:0]   r_data;
    logic [31:0]                r_gap_cnt;

    logic                       w_found;
    logic [PTR_W-1:0]           w_pick;
    logic [TX_DATA_WIDTH-1:0]   w_sel_data;
    logic                       w_timeout_hit;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    // Search starts one past the last owner so the last winner ranks lowest.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!w_found && req_i[wrap_idx(r_ptr, i)]) begin
                w_found = 1'b1;
                w_pick  = wrap_idx(r_ptr, i);
            end
        end
    end

    assign w_sel_data = data_i[int'(w_pick)*TX_DATA_WIDTH +: TX_DATA_WIDTH];

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] r_wdog;
    logic        r_timeout;

    assign w_timeout_hit = (r_state == S_WAIT_END) && !uart_tx_end_i &&
                           (r_wdog == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == S_WAIT_END) r_wdog <= r_wdog + 32'd1;
            else                       r_wdog <= '0;
            if (w_timeout_hit) r_timeout <= 1'b1;
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_o     = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state   <= S_IDLE;
            r_ptr     <= PTR_W'(NUM_REQ - 1);
            r_grant   <= '0;
            r_done    <= '0;
            r_start   <= 1'b0;
            r_data    <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_done  <= '0;
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= NUM_REQ'(1) << w_pick;
                        r_data  <= w_sel_data;
                        r_start <= 1'b1;
                        r_ptr   <= w_pick;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT_END;
                end
                S_WAIT_END: begin
                    if (uart_tx_end_i || w_timeout_hit) begin
                        r_done  <= r_grant;
                        r_grant <= '0;
                        r_state <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == 32'(GAP_CYCLES - 1)) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 32'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant_o         = r_grant;
    assign done_o          = r_done;
    assign uart_tx_start_o = r_start;
    assign uart_data_tx_o  = r_data;
    assign busy_o          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a round-robin reference model
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int GAP = 10;
    localparam int TMO = 100;

    logic             clk = 1'b0;
    logic             reset_i;
    logic [N-1:0]     r_req;
    logic [W-1:0]     r_byte [N];
    logic [N*W-1:0]   data_i;
    logic [N-1:0]     grant_o;
    logic [N-1:0]     done_o;
    logic             uart_tx_start_o;
    logic [W-1:0]     uart_data_tx_o;
    logic             end_i;
    logic             busy_o;
    logic             timeout_o;

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) data_i[i*W +: W] = r_byte[i];
    end

    uart_tx_arbiter #(
        .NUM_REQ(N), .TX_DATA_WIDTH(W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .req_i(r_req), .data_i(data_i),
        .grant_o(grant_o), .done_o(done_o), .uart_tx_start_o(uart_tx_start_o),
        .uart_data_tx_o(uart_data_tx_o), .uart_tx_end_i(end_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: owner is the first pending index after the previous owner, wrapping.
    function automatic int model_pick(input logic [N-1:0] req, input int ptr);
        for (int off = 1; off <= N; off++)
            if (req[(ptr + off) % N]) return (ptr + off) % N;
        return -1;
    endfunction

    task automatic wait_start(output bit seen, output int lat);
        seen = 0;
        lat  = 0;
        while (!seen && lat < 50) begin
            @(negedge clk);
            lat++;
            if (uart_tx_start_o === 1'b1) seen = 1;
        end
        check("start_seen", 32'(seen), 32'd1);
    endtask

    // One full byte: grant, optional end during START, hold, end, gap.
    task automatic xfer(input int end_delay, input bit coincide, input bit gap_spur, output logic [W-1:0] got);
        int k, lat;
        bit seen, ok;
        logic [W-1:0] exp_byte;
        k        = model_pick(r_req, m_ptr);
        exp_byte = r_byte[k];
        got      = '0;
        wait_start(seen, lat);
        if (!seen) return;
        m_ptr = k;
        got   = uart_data_tx_o;
        check("latency", 32'(lat), 32'd1);
        check("grant", 32'(grant_o), 32'(1 << k));
        check("data", 32'(uart_data_tx_o), 32'(exp_byte));
        if (coincide) end_i = 1'b1;
        @(negedge clk);
        end_i = 1'b0;
        check("start_width", 32'(uart_tx_start_o), 32'd0);
        if (coincide) check("end_in_start_ignored", 32'({grant_o, done_o}), 32'({4'(1 << k), 4'b0}));
        ok = 1;
        repeat (end_delay) begin
            if (grant_o !== 4'(1 << k) || uart_data_tx_o !== exp_byte || done_o !== '0 || busy_o !== 1'b1) ok = 0;
            @(negedge clk);
        end
        check("hold", 32'(ok), 32'd1);
        end_i = 1'b1;
        @(negedge clk);
        end_i = 1'b0;
        check("done", 32'(done_o), 32'(1 << k));
        check("grant_clr", 32'(grant_o), 32'd0);
        ok = 1;
        for (int g = 1; g <= GAP; g++) begin
            if (gap_spur && g == 3) end_i = 1'b1;
            @(negedge clk);
            end_i = 1'b0;
            if (done_o !== '0 || uart_tx_start_o !== 1'b0) ok = 0;
            if (g < GAP && busy_o !== 1'b1) ok = 0;
        end
        check("gap_quiet", 32'(ok), 32'd1);
        check("gap_len_busy_low", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] got;
        logic [W-1:0] rr_exp [5];
        bit seen, ok;
        int lat, cnt;

        reset_i = 1'b0;
        end_i   = 1'b0;
        r_req   = 4'b1111;
        for (int i = 0; i < N; i++) r_byte[i] = 8'(8'h10 + i);
        m_ptr = N - 1;
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({grant_o, done_o, uart_tx_start_o, uart_data_tx_o, busy_o, timeout_o}), 32'd0);
        reset_i = 1'b1;

        // All four pending: strict rotation starting at index 0.
        rr_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        for (int t = 0; t < 5; t++) begin
            xfer(3 + t, t == 2, t == 1, got);
            check("rr_order", 32'(got), 32'(rr_exp[t]));
        end

        r_req     = 4'b0100;
        r_byte[2] = 8'hA5;
        xfer(20, 1'b0, 1'b0, got);
        check("single_byte", 32'(got), 32'hA5);

        r_req = '0;
        end_i = 1'b1;
        @(negedge clk);
        end_i = 1'b0;
        ok = 1;
        repeat (4) begin
            if (busy_o !== 1'b0 || done_o !== '0 || grant_o !== '0 || uart_tx_start_o !== 1'b0) ok = 0;
            @(negedge clk);
        end
        check("idle_spurious_end", 32'(ok), 32'd1);

        for (int t = 0; t < 12; t++) begin
            r_req = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) r_byte[i] = 8'($urandom);
            xfer(int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)), 1'b0, got);
        end

        r_req = 4'b0110;
        wait_start(seen, lat);
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("rst_mid_outputs", 32'({grant_o, uart_tx_start_o, busy_o}), 32'd0);
        ok = 1;
        repeat (3) begin
            @(negedge clk);
            if (done_o !== '0 || grant_o !== '0) ok = 0;
        end
        check("rst_mid_no_done", 32'(ok), 32'd1);
        r_req   = 4'b0101;
        m_ptr   = N - 1;
        reset_i = 1'b1;
        xfer(4, 1'b0, 1'b0, got);
        check("rst_rearb_idx0", 32'(m_ptr), 32'd0);

`ifdef UART_ARB_TIMEOUT_EN
        r_req = 4'b0010;
        wait_start(seen, lat);
        m_ptr = 1;
        cnt = 0;
        while (done_o === '0 && cnt < 3 * TMO) begin
            @(negedge clk);
            cnt++;
        end
        check("wdog_cycles", 32'(cnt), 32'(TMO + 1));
        check("wdog_done", 32'(done_o), 32'b0010);
        check("wdog_flag", 32'(timeout_o), 32'd1);
        r_req = 4'b0100;
        cnt = 0;
        while (busy_o !== 1'b0 && cnt < 3 * GAP) begin
            @(negedge clk);
            cnt++;
        end
        check("wdog_gap", 32'(cnt), 32'(GAP));
        xfer(5, 1'b0, 1'b0, got);
        check("wdog_next_served", 32'(m_ptr), 32'd2);
        check("wdog_sticky", 32'(timeout_o), 32'd1);
`else
        check("timeout_tied_low", 32'(timeout_o), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
